// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int MASK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory port of mem_arbiter.
// The slave modport is the arbiter side; master is the core/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_ren, mem_wdata, mem_wmask
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_ren, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive denied fetch cycles; force_i lets fetch win
// once the count reaches STARVE_MAX.
module mem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    output logic force_i
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_p1 <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt_p1 <= '0;
        end else if (starve_cnt_p1 != CNT_MAX) begin
            starve_cnt_p1 <= starve_cnt_p1 + 1'b1;
        end
    end

    assign force_i = (starve_cnt_p1 == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency memory between fetch (I) and
// load/store (D). Optional perf counters: define MEM_ARB_PERF_CNT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]  perf_i_gnt,
    output logic [31:0]  perf_d_gnt,
    output logic [31:0]  perf_conflict
`endif
);

    logic              force_i;
    logic              i_gnt_c;
    logic              d_gnt_c;
    logic              d_is_wr;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_ren_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [MASK_W-1:0] mem_wmask_c;
    logic [ADDR_W-1:0] last_addr_p1;
    owner_e            owner_p1;

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_req   (bus.i_req),
        .i_gnt   (i_gnt_c),
        .force_i (force_i)
    );

    // Stage p0: combinational grant and memory command from this cycle's requests
    assign d_is_wr = |bus.d_wmask;
    assign i_gnt_c = !reset && bus.i_req && (!bus.d_req || force_i);
    assign d_gnt_c = !reset && bus.d_req && !(bus.i_req && force_i);

    always_comb begin
        mem_addr_c  = last_addr_p1;
        mem_ren_c   = 1'b0;
        mem_wdata_c = '0;
        mem_wmask_c = '0;
        if (i_gnt_c) begin
            mem_addr_c = bus.i_addr;
            mem_ren_c  = 1'b1;
        end else if (d_gnt_c) begin
            mem_addr_c = bus.d_addr;
            mem_ren_c  = !d_is_wr;
            if (d_is_wr) begin
                mem_wdata_c = bus.d_wdata;
                mem_wmask_c = bus.d_wmask;
            end
        end
    end

    // Stage p1: owner of the read returning from memory this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_p1     <= OWN_NONE;
            last_addr_p1 <= '0;
        end else begin
            last_addr_p1 <= mem_addr_c;
            if (i_gnt_c) begin
                owner_p1 <= OWN_I;
            end else if (d_gnt_c && !d_is_wr) begin
                owner_p1 <= OWN_D;
            end else begin
                owner_p1 <= OWN_NONE;
            end
        end
    end

    assign bus.i_gnt     = i_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_ren   = mem_ren_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_wmask = mem_wmask_c;

    // Reset gates the responses so a read in flight at reset is dropped
    assign bus.i_rvalid = !reset && (owner_p1 == OWN_I);
    assign bus.d_rvalid = !reset && (owner_p1 == OWN_D);
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_gnt    <= '0;
            perf_d_gnt    <= '0;
            perf_conflict <= '0;
        end else begin
            if (i_gnt_c) begin
                perf_i_gnt <= perf_i_gnt + 32'd1;
            end
            if (d_gnt_c) begin
                perf_d_gnt <= perf_d_gnt + 32'd1;
            end
            if (bus.i_req && bus.d_req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule
